// File: rtl/array_serializer.sv
// Purpose: snapshots a flattened NUM_ELEMS x ELEM_W array on start and streams it out as OUT_W-bit chunks.
// Latency: first beat is valid the cycle after start; one beat per cycle while out_ready is high.
// Backpressure: out_valid/out_data/out_last hold stable while out_ready is low; no beat is dropped.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset (reset beats start)
//   start, in_data       begin a frame and capture in_data (honoured only when idle)
//   out_data/out_valid/out_ready/out_last   chunk stream, element 0 LS chunk first
//   busy, done           frame in progress / one-cycle pulse after the final transfer
//
// Optional: define SER_CHECKSUM_EN to append one XOR-of-all-chunks beat to each frame.
module array_serializer #(
    parameter int NUM_ELEMS = 9,
    parameter int ELEM_W    = 18,
    parameter int OUT_W     = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [NUM_ELEMS*ELEM_W-1:0] in_data,
    output logic [OUT_W-1:0]            out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        busy,
    output logic                        done
);

    localparam int CHUNKS = (ELEM_W + OUT_W - 1) / OUT_W;
    localparam int IW     = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;
    localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int PW     = CHUNKS * OUT_W;

`ifdef SER_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, SEND, CSUM, FIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;
`endif

    state_t                      state_q;
    state_t                      state_d;
    logic [NUM_ELEMS*ELEM_W-1:0] snapshot;
    logic [IW-1:0]               elem_idx;
    logic [CW-1:0]               chunk_idx;
    logic [PW-1:0]               elem_pad;
    logic [OUT_W-1:0]            cur_chunk;
    logic                        last_data;
    logic                        take_start;
    logic                        data_xfer;

    assign take_start = (state_q == IDLE) && start;
    assign data_xfer  = (state_q == SEND) && out_ready;
    assign last_data  = (elem_idx == IW'(NUM_ELEMS - 1)) && (chunk_idx == CW'(CHUNKS - 1));

    // Widen the selected element to a whole number of chunks so the top
    // chunk comes out zero-padded when ELEM_W is not a multiple of OUT_W.
    always_comb begin
        elem_pad                = '0;
        elem_pad[ELEM_W-1:0]    = snapshot[int'(elem_idx) * ELEM_W +: ELEM_W];
        cur_chunk               = elem_pad[int'(chunk_idx) * OUT_W +: OUT_W];
    end

    // Snapshot only changes on an accepted start, so in-flight frames are immune
    // to later in_data changes. It is never read outside SEND, so no reset needed.
    always_ff @(posedge clk) begin
        if (take_start && !reset) begin
            snapshot <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            elem_idx  <= '0;
            chunk_idx <= '0;
        end else begin
            state_q <= state_d;
            if (take_start) begin
                elem_idx  <= '0;
                chunk_idx <= '0;
            end else if (data_xfer) begin
                if (last_data) begin
                    elem_idx  <= '0;
                    chunk_idx <= '0;
                end else if (chunk_idx == CW'(CHUNKS - 1)) begin
                    chunk_idx <= '0;
                    elem_idx  <= elem_idx + IW'(1);
                end else begin
                    chunk_idx <= chunk_idx + CW'(1);
                end
            end
        end
    end

`ifdef SER_CHECKSUM_EN
    logic [OUT_W-1:0] csum_q;

    always_ff @(posedge clk) begin
        if (reset || take_start) begin
            csum_q <= '0;
        end else if (data_xfer) begin
            csum_q <= csum_q ^ cur_chunk;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        out_data  = '0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                out_data  = cur_chunk;
`ifdef SER_CHECKSUM_EN
                if (out_ready && last_data) begin
                    state_d = CSUM;
                end
`else
                out_last = last_data;
                if (out_ready && last_data) begin
                    state_d = FIN;
                end
`endif
            end
`ifdef SER_CHECKSUM_EN
            CSUM: begin
                out_valid = 1'b1;
                out_data  = csum_q;
                out_last  = 1'b1;
                if (out_ready) begin
                    state_d = FIN;
                end
            end
`endif
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_array_serializer.sv
module tb_array_serializer;

    logic         clk = 1'b0;
    logic         reset;
    logic         out_ready;

    // Default-parameter instance (9 x 18 -> 8)
    logic         b_start;
    logic [161:0] b_in;
    logic [7:0]   b_out_data;
    logic         b_out_valid, b_out_last, b_busy, b_done;

    // Small instance (2 x 16 -> 8)
    logic         s_start;
    logic [31:0]  s_in;
    logic [7:0]   s_out_data;
    logic         s_out_valid, s_out_last, s_busy, s_done;

    int           total = 0;
    int           bad   = 0;
    logic [7:0]   expq[$];

    always #5 clk = ~clk;

    array_serializer dut_big (
        .clk(clk), .reset(reset), .start(b_start), .in_data(b_in),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_last(b_out_last), .busy(b_busy), .done(b_done)
    );

    array_serializer #(.NUM_ELEMS(2), .ELEM_W(16), .OUT_W(8)) dut_small (
        .clk(clk), .reset(reset), .start(s_start), .in_data(s_in),
        .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_last(s_out_last), .busy(s_busy), .done(s_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [17:0] elem(input int k);
        return 18'h30000 | 18'(k << 8) | 18'(k);
    endfunction

    task automatic push_big(input logic [161:0] d);
        for (int k = 0; k < 9; k++) begin
            logic [17:0] e;
            e = d[k*18 +: 18];
            for (int j = 0; j < 3; j++) begin
                expq.push_back(8'(e >> (8 * j)));
            end
        end
    endtask

    task automatic set_start(input bit sel, input logic v);
        if (sel) s_start = v;
        else     b_start = v;
    endtask

    // One frame: start, then step cycle by cycle comparing each transferred
    // beat against the scoreboard queue. rmode 1 drives out_ready 1,0,0,1.
    // poke_beat >= 0 raises start mid-frame and again in the FIN cycle.
    // abort_beat >= 0 asserts reset once that many beats have transferred.
    task automatic run_frame(input string tag, input bit sel, input int rmode,
                             input int poke_beat, input int abort_beat, input bit corrupt);
        int         nb = 0, nv = 0, ncyc = 0, nexp;
        bit         stall = 0, last_x = 0, fin = 0;
        logic [7:0] od, pd = '0;
        logic       ov, ol, ob, odn, pl = 1'b0;

        nexp = expq.size();
        out_ready = 1'b1;
        set_start(sel, 1'b1);
        cyc();
        set_start(sel, 1'b0);
        if (corrupt) b_in = '1;
        ov = sel ? s_out_valid : b_out_valid;
        ob = sel ? s_busy : b_busy;
        chk({tag, "_latency_valid"}, ov, 1);
        chk({tag, "_latency_busy"}, ob, 1);

        while (!fin && ncyc < 400) begin
            out_ready = (rmode == 0) ? 1'b1 : ((ncyc % 4 == 0) || (ncyc % 4 == 3));
            if (poke_beat >= 0) set_start(sel, (nb == poke_beat) || (nb == nexp));
            od  = sel ? s_out_data  : b_out_data;
            ov  = sel ? s_out_valid : b_out_valid;
            ol  = sel ? s_out_last  : b_out_last;
            ob  = sel ? s_busy      : b_busy;
            odn = sel ? s_done      : b_done;

            if (abort_beat >= 0 && nb == abort_beat) begin
                reset = 1'b1;
                cyc();
                reset = 1'b0;
                ov  = sel ? s_out_valid : b_out_valid;
                ob  = sel ? s_busy      : b_busy;
                odn = sel ? s_done      : b_done;
                chk({tag, "_abort_valid"}, ov, 0);
                chk({tag, "_abort_busy"}, ob, 0);
                chk({tag, "_abort_done"}, odn, 0);
                expq.delete();
                return;
            end

            if (stall) begin
                chk({tag, "_stall_data"}, od, pd);
                chk({tag, "_stall_last"}, ol, pl);
                chk({tag, "_stall_valid"}, ov, 1);
            end
            chk({tag, "_done"}, odn, last_x);
            if (last_x) begin
                chk({tag, "_fin_busy"}, ob, 1);
                chk({tag, "_fin_valid"}, ov, 0);
                fin = 1;
            end
            if (ov) nv++;
            if (ov && out_ready) begin
                if (expq.size() == 0) begin
                    chk({tag, "_extra_beat"}, 1, 0);
                    last_x = 0;
                end else begin
                    logic [7:0] e;
                    e = expq.pop_front();
                    chk($sformatf("%s_beat%0d_data", tag, nb), od, e);
                    chk($sformatf("%s_beat%0d_last", tag, nb), ol, expq.size() == 0);
                    last_x = (expq.size() == 0);
                end
                nb++;
            end else begin
                last_x = 0;
            end
            stall = ov && !out_ready;
            pd = od;
            pl = ol;
            ncyc++;
            cyc();
        end
        set_start(sel, 1'b0);
        chk({tag, "_completed"}, fin, 1);
        chk({tag, "_beat_count"}, nb, nexp);
        if (rmode == 0) chk({tag, "_valid_cycles"}, nv, nexp);
        ov  = sel ? s_out_valid : b_out_valid;
        ob  = sel ? s_busy      : b_busy;
        odn = sel ? s_done      : b_done;
        chk({tag, "_idle_busy"}, ob, 0);
        chk({tag, "_idle_done"}, odn, 0);
        chk({tag, "_idle_valid"}, ov, 0);
        expq.delete();
    endtask

    initial begin
        logic [161:0] orig;

        reset     = 1'b1;
        b_start   = 1'b0;
        s_start   = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 9; k++) b_in[k*18 +: 18] = elem(k);
        orig = b_in;
        s_in = {16'hABCD, 16'h1234};
        @(negedge clk);
        cyc();

        chk("reset_valid", b_out_valid, 0);
        chk("reset_last", b_out_last, 0);
        chk("reset_busy", b_busy, 0);
        chk("reset_done", b_done, 0);
        chk("reset_data", b_out_data, 0);

        // start and reset together: reset must win
        b_start = 1'b1;
        cyc();
        b_start = 1'b0;
        reset   = 1'b0;
        chk("reset_beats_start_busy", b_busy, 0);
        cyc();
        chk("reset_beats_start_valid", b_out_valid, 0);

        push_big(orig);
        run_frame("basic", 0, 0, -1, -1, 0);

        push_big(orig);
        run_frame("backpressure", 0, 1, -1, -1, 0);

        push_big(orig);
        run_frame("snapshot", 0, 0, -1, -1, 1);
        b_in = orig;

        push_big(orig);
        run_frame("start_busy", 0, 0, 10, -1, 0);

        push_big(orig);
        run_frame("abort", 0, 0, -1, 5, 0);
        cyc();
        push_big(orig);
        run_frame("after_abort", 0, 0, -1, -1, 0);

        expq.push_back(8'h34);
        expq.push_back(8'h12);
        expq.push_back(8'hCD);
        expq.push_back(8'hAB);
`ifdef SER_CHECKSUM_EN
        expq.push_back(8'h40);
`endif
        run_frame("small", 1, 0, -1, -1, 0);

        expq.push_back(8'h34);
        expq.push_back(8'h12);
        expq.push_back(8'hCD);
        expq.push_back(8'hAB);
`ifdef SER_CHECKSUM_EN
        expq.push_back(8'h40);
`endif
        run_frame("small_bp", 1, 1, -1, -1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
